// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg
// Shared constants for the operand-fetch slice: ALU opcode encoding and
// width, register-file geometry, and the writeback-match helper used by the
// capture bypass and the stall refresh.
package operand_fetch_pkg;

    // ALU opcode width and codes; the fetch stage only passes these through.
    localparam int ALU_OP_LENGTH = 4;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_ADD = 4'd0;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SUB = 4'd1;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_AND = 4'd2;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_OR  = 4'd3;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_XOR = 4'd4;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLL = 4'd5;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SRL = 4'd6;
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SRA = 4'd7;

    // Register-file geometry.
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    // True when the writeback port is updating source register rs this
    // cycle. x0 never matches because it is hard-wired to zero.
    function automatic logic wb_hit(input logic                 en,
                                    input logic [REG_IDX_W-1:0] wb_rd,
                                    input logic [REG_IDX_W-1:0] rs);
        return en && (wb_rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// regfile_2r1w
// 32 x 32-bit register file with two combinational read ports and one
// synchronous write port. x0 always reads zero and ignores writes.
// Ports:
//   clk, resetn          clock, synchronous active-low reset (clears array)
//   raddr_a/b, rdata_a/b combinational read ports
//   we, waddr, wdata     write port, applied at the rising edge
module regfile_2r1w
    import operand_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [XLEN-1:0]      rdata_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [XLEN-1:0]      rdata_b,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]      wdata
);

    logic [XLEN-1:0] mem_q [NUM_REGS];

    // Array storage: cleared in reset, writes to x0 dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= {XLEN{1'b0}};
            end
        end else if (we && (waddr != 5'd0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read ports: x0 forced to zero regardless of array contents.
    always_comb begin
        rdata_a = {XLEN{1'b0}};
        rdata_b = {XLEN{1'b0}};
        if (raddr_a != 5'd0) begin
            rdata_a = mem_q[raddr_a];
        end else begin
            rdata_a = {XLEN{1'b0}};
        end
        if (raddr_b != 5'd0) begin
            rdata_b = mem_q[raddr_b];
        end else begin
            rdata_b = {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
// Reads ALU operands from the register file and presents them to the ALU
// through a one-entry output register with valid/ready handshake.
// Writeback data is bypassed at capture, and a stalled (held) instruction
// has its register operands refreshed if their source is written meanwhile.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   in_valid/in_ready           upstream handshake (in_ready combinational)
//   in_rs1, in_rs2, in_imm, in_use_imm, in_opcode, in_rd   decoded fields
//   wb_en, wb_rd, wb_data       register writeback port
//   out_valid/out_ready         downstream handshake
//   out_left, out_right, out_opcode, out_rd   registered ALU operands
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int OP_W = ALU_OP_LENGTH
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [31:0]     in_imm,
    input  logic            in_use_imm,
    input  logic [OP_W-1:0] in_opcode,
    input  logic [4:0]      in_rd,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [31:0]     wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_left,
    output logic [31:0]     out_right,
    output logic [OP_W-1:0] out_opcode,
    output logic [4:0]      out_rd
);

    logic            valid_q,   valid_d;
    logic [31:0]     left_q,    left_d;
    logic [31:0]     right_q,   right_d;
    logic [OP_W-1:0] opcode_q,  opcode_d;
    logic [4:0]      rd_q,      rd_d;
    // Source identity of the held instruction, needed for stall refresh.
    logic [4:0]      rs1_q,     rs1_d;
    logic [4:0]      rs2_q,     rs2_d;
    logic            use_imm_q, use_imm_d;

    logic [31:0]     rf_a_s;
    logic [31:0]     rf_b_s;
    logic            accept_s;
    logic [31:0]     cap_left_s;
    logic [31:0]     cap_right_s;

    regfile_2r1w u_regfile (
        .clk     (clk),
        .resetn  (resetn),
        .raddr_a (in_rs1),
        .rdata_a (rf_a_s),
        .raddr_b (in_rs2),
        .rdata_b (rf_b_s),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data)
    );

    // Upstream handshake; resetn gates it so nothing is taken during reset.
    always_comb begin
        in_ready = resetn && (!valid_q || out_ready);
        accept_s = in_valid && in_ready;
    end

    // Operand selection at capture: same-cycle writeback wins over the array.
    always_comb begin
        cap_left_s  = rf_a_s;
        cap_right_s = rf_b_s;
        if (wb_hit(wb_en, wb_rd, in_rs1)) begin
            cap_left_s = wb_data;
        end else begin
            cap_left_s = rf_a_s;
        end
        if (in_use_imm) begin
            cap_right_s = in_imm;
        end else if (wb_hit(wb_en, wb_rd, in_rs2)) begin
            cap_right_s = wb_data;
        end else begin
            cap_right_s = rf_b_s;
        end
    end

    // Output-register next state: load on accept, drain on consume,
    // refresh held register operands while stalled.
    always_comb begin
        valid_d   = valid_q;
        left_d    = left_q;
        right_d   = right_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        if (accept_s) begin
            valid_d   = 1'b1;
            left_d    = cap_left_s;
            right_d   = cap_right_s;
            opcode_d  = in_opcode;
            rd_d      = in_rd;
            rs1_d     = in_rs1;
            rs2_d     = in_rs2;
            use_imm_d = in_use_imm;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            if (wb_hit(wb_en, wb_rd, rs1_q)) begin
                left_d = wb_data;
            end else begin
                left_d = left_q;
            end
            // An immediate operand never depends on the register file.
            if (!use_imm_q && wb_hit(wb_en, wb_rd, rs2_q)) begin
                right_d = wb_data;
            end else begin
                right_d = right_q;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output and held-instruction registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q   <= 1'b0;
            left_q    <= 32'd0;
            right_q   <= 32'd0;
            opcode_q  <= {OP_W{1'b0}};
            rd_q      <= 5'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            use_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            left_q    <= left_d;
            right_q   <= right_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_left   = left_q;
    assign out_right  = right_q;
    assign out_opcode = opcode_q;
    assign out_rd     = rd_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter ALU_OP_LENGTH, default from shared parameters.vh, ALU opcode width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  upstream decode presents an instruction.
REQ-005 in_ready  out  1  block accepts the instruction this cycle.
REQ-006 in_rs1, in_rs2  in  5 each  source register indices.
REQ-007 in_imm  in  32  sign-extended immediate.
REQ-008 in_use_imm  in  1  right operand = in_imm instead of rs2.
REQ-009 in_opcode  in  ALU_OP_LENGTH  ALU opcode, passed through.
REQ-010 in_rd  in  5  destination index, passed through.
REQ-011 wb_en, wb_rd[4:0], wb_data[31:0]  in  writeback port.
REQ-012 out_valid  out  1  operands valid toward the ALU.
REQ-013 out_ready  in  1  downstream consumes this cycle.
REQ-014 out_left, out_right  out  32 each  registered ALU operands.
REQ-015 out_opcode  out  ALU_OP_LENGTH; out_rd  out  5  registered pass-through.

Function
REQ-016 Register file: 32 x 32 bits; x0 reads 0; writes to x0 ignored.
REQ-017 Write: wb_en=1 and wb_rd!=0 -> regs[wb_rd] <= wb_data at the edge.
REQ-018 in_ready = !out_valid | out_ready (combinational; one-entry output register).
REQ-019 Accept = in_valid & in_ready; on accept, all out_* load and out_valid <= 1. Latency is one cycle from accept to out_valid.
REQ-020 out_valid & out_ready & !accept -> out_valid <= 0; outputs hold their last values.
REQ-021 out_valid & !out_ready -> all out_* hold, except as required by REQ-023.
REQ-022 Bypass at capture: wb_en & wb_rd==rsN & rsN!=0 -> operand takes wb_data, not the stale array value.
REQ-023 Stall refresh: while out_valid & !out_ready, wb_en & wb_rd==held rs1 (nonzero) -> out_left <= wb_data. Same rule for out_right only when held use_imm=0.
REQ-024 Held rs1, rs2 and use_imm are kept internally for REQ-023. They are not outputs.
REQ-025 in_use_imm=1 -> out_right = in_imm. rs2 is ignored for bypass and refresh.
REQ-026 Accept and writeback in the same cycle: both occur. The bypass value is captured.
REQ-027 No arithmetic is performed. All widths are exact; no truncation or extension beyond in_imm as given.

Reset
REQ-028 resetn=0 at an edge: out_valid <= 0. out_left, out_right, out_rd, out_opcode <= 0. All 31 writable registers <= 0.
REQ-029 During reset, in_ready = 0 and writeback is ignored.
REQ-030 Reset mid-stall discards the held instruction with no output handshake.

Structure
REQ-031 ALU_OP_* codes and ALU_OP_LENGTH belong in shared parameters.vh. Register count (32) and index width (5) are added there as constants.
REQ-032 The array is the sub-module regfile_2r1w: two combinational read ports, one synchronous write port, x0 forced 0.
REQ-033 Handshake, bypass and refresh logic live in operand_fetch. Total RTL is about 150-250 lines.

Verification
REQ-034 Reset, then write x5=0x0000_00AA. Next cycle issue rs1=5, rs2=0, use_imm=0 -> out_left=0xAA, out_right=0, out_valid=1 one cycle later.
REQ-035 Write x0=0xFFFF_FFFF, then read rs1=0 -> out_left=0.
REQ-036 Same cycle: wb x7=0x1234_5678 and accept rs1=7, rs2=7 -> both operands 0x1234_5678.
REQ-037 Hold out_ready=0 with held rs2=3, use_imm=0. Write x3=0xDEAD_BEEF -> out_right becomes 0xDEAD_BEEF next cycle, in_ready=0. Repeat with use_imm=1, imm=0x10 -> out_right stays 0x10.
REQ-038 Back-to-back: in_valid=1 and out_ready=1 for 4 cycles -> 4 results in order, no bubbles, in_ready constant 1.
REQ-039 Assert resetn=0 while stalled with out_valid=1 -> next cycle out_valid=0 and x5 reads 0.
